synaptic_current_accumulator: RTL and testbench

Upstream feeder of the Izhikevich state-update stage. Buffers weighted synaptic spike events arriving during a simulation timestep. At each timestep strobe it integrates them into a decaying synaptic current. It publishes that current as the 17-bit sign-magnitude `i_in` operand for the neuron stage.

---
 rtl/izh_fixed_pkg.sv | 55 +++++
 rtl/event_fifo.sv | 48 ++++
 rtl/synaptic_current_accumulator.sv | 116 +++++++++++
 tb/tb_synaptic_current_accumulator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_fixed_pkg.sv
// Shared 17-bit sign-magnitude fixed-point format (8 fractional bits) used by the
// synaptic accumulator and the Izhikevich neuron stage.
package izh_fixed_pkg;

    localparam int WIDTH = 17;
    localparam int FRAC = 8;
    localparam logic [15:0] MAG_MAX = 16'hFFFF;

    // Regular-spiking neuron constants in the shared sign-magnitude format.
    localparam logic [WIDTH-1:0] IZH_A = 17'h00005;   // 0.02
    localparam logic [WIDTH-1:0] IZH_B = 17'h00033;   // 0.2
    localparam logic [WIDTH-1:0] IZH_C = 17'h14100;   // -65.0
    localparam logic [WIDTH-1:0] IZH_D = 17'h00800;   // 8.0

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic signed [17:0] value;
        logic clamped;
    } sat_res_t;

    function automatic logic signed [17:0] sm_to_tc(input logic [WIDTH-1:0] sm);
        logic signed [17:0] m;
        m = signed'({2'b00, sm[15:0]});
        return sm[16] ? -m : m;
    endfunction

    // Negative zero never leaves this function: a zero magnitude is always positive.
    function automatic logic [WIDTH-1:0] tc_to_sm(input logic signed [17:0] v);
        logic [15:0] m;
        m = v[17] ? 16'(-v) : v[15:0];
        return (m == 16'd0) ? '0 : {v[17], m};
    endfunction

    function automatic sat_res_t sat_add(input logic signed [17:0] a, input logic signed [17:0] b);
        logic signed [18:0] s;
        sat_res_t r;
        s = 19'(a) + 19'(b);
        if (s > 19'sd65535) begin
            r.value = 18'sd65535;
            r.clamped = 1'b1;
        end else if (s < -19'sd65535) begin
            r.value = -18'sd65535;
            r.clamped = 1'b1;
        end else begin
            r.value = 18'(s);
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO; pointers wrap modulo DEPTH, count is log2(DEPTH)+1 bits.
module event_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     asyn_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// Buffers weighted spike events per timestep, integrates them into a decaying
// synaptic current and publishes it as the neuron stage's sign-magnitude i_in.
//
// state | meaning
// ACCUM | accepting events into the FIFO, acc holds, waiting for step
// DRAIN | popping one event per cycle into acc; publishes and decays when empty
module synaptic_current_accumulator
    import izh_fixed_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAU_SHIFT = 2
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             ev_valid,
    input  logic [WIDTH-1:0] ev_weight,
    output logic             ev_ready,
    input  logic             step,
    output logic [WIDTH-1:0] i_out,
    output logic             i_valid,
    output logic             busy,
    output logic             sat
);

    localparam int CW = $clog2(DEPTH) + 1;

    acc_state_t state;
    acc_state_t state_next;

    logic [WIDTH-1:0] fifo_dout;
    logic fifo_full;
    logic fifo_empty;
    logic [CW-1:0] fifo_count;
    logic push;
    logic pop;
    logic publish;

    logic signed [17:0] acc;
    logic [WIDTH-1:0] acc_sm;
    logic [15:0] decayed_mag;
    logic signed [17:0] acc_decayed;
    sat_res_t sum;

    event_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk(clk),
        .asyn_reset(asyn_reset),
        .push(push),
        .pop(pop),
        .din(ev_weight),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) state <= ACCUM;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (step) state_next = DRAIN;
            DRAIN: if (fifo_empty) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs depend only on registered state and FIFO occupancy.
    always_comb begin
        ev_ready = 1'b0;
        busy = 1'b0;
        pop = 1'b0;
        publish = 1'b0;
        case (state)
            ACCUM: ev_ready = !fifo_full;
            DRAIN: begin
                busy = 1'b1;
                pop = (fifo_count != '0);
                publish = fifo_empty;
            end
            default: ;
        endcase
    end

    assign push = ev_valid && ev_ready;

    // Decay works on the magnitude so negative currents shrink toward zero too.
    assign acc_sm = tc_to_sm(acc);
    assign decayed_mag = acc_sm[15:0] - (acc_sm[15:0] >> TAU_SHIFT);
    assign acc_decayed = sm_to_tc({acc_sm[16], decayed_mag});
    assign sum = sat_add(acc, sm_to_tc(fifo_dout));

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            acc <= '0;
            i_out <= '0;
            i_valid <= 1'b0;
            sat <= 1'b0;
        end else begin
            i_valid <= publish;
            if (publish) begin
                i_out <= acc_sm;
                acc <= acc_decayed;
            end else if (pop) begin
                acc <= sum.value;
                if (sum.clamped) sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized timesteps against an integer reference model.
module tb_synaptic_current_accumulator;

    localparam int DEPTH = 8;
    localparam int TAU = 2;

    logic clk = 1'b0;
    logic asyn_reset = 1'b1;
    logic ev_valid = 1'b0;
    logic [16:0] ev_weight = '0;
    logic ev_ready;
    logic step = 1'b0;
    logic [16:0] i_out;
    logic i_valid;
    logic busy;
    logic sat;

    int checks = 0;
    int errors = 0;

    int m_acc = 0;
    bit m_sat = 1'b0;
    int m_q[$];

    synaptic_current_accumulator #(
        .DEPTH(DEPTH),
        .TAU_SHIFT(TAU)
    ) dut (
        .clk(clk),
        .asyn_reset(asyn_reset),
        .ev_valid(ev_valid),
        .ev_weight(ev_weight),
        .ev_ready(ev_ready),
        .step(step),
        .i_out(i_out),
        .i_valid(i_valid),
        .busy(busy),
        .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int n;
        logic [16:0] w[3];
        logic [16:0] exp_out;
        int exp_lat;
        bit exp_sat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int sm2i(input logic [16:0] w);
        return w[16] ? -int'(w[15:0]) : int'(w[15:0]);
    endfunction

    function automatic logic [16:0] i2sm(input int v);
        return (v < 0) ? {1'b1, 16'(-v)} : {1'b0, 16'(v)};
    endfunction

    function automatic void model_reset();
        m_acc = 0;
        m_sat = 1'b0;
        m_q.delete();
    endfunction

    // Integrate all queued weights with clamping, publish, then decay the magnitude.
    function automatic logic [16:0] model_step();
        int s;
        int mag;
        logic [16:0] out;
        foreach (m_q[k]) begin
            s = m_acc + m_q[k];
            if (s > 65535) begin s = 65535; m_sat = 1'b1; end
            if (s < -65535) begin s = -65535; m_sat = 1'b1; end
            m_acc = s;
        end
        m_q.delete();
        out = i2sm(m_acc);
        mag = (m_acc < 0) ? -m_acc : m_acc;
        mag = mag - mag / (1 << TAU);
        m_acc = (m_acc < 0) ? -mag : mag;
        return out;
    endfunction

    // Called and returns at a falling edge.
    task automatic do_reset();
        #2 asyn_reset = 1'b1;
        ev_valid = 1'b0;
        step = 1'b0;
        @(negedge clk);
        asyn_reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic push(input logic [16:0] w);
        int t = 0;
        ev_valid = 1'b1;
        ev_weight = w;
        while (!ev_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("push_timeout", 32'(t), 32'd0);
        @(negedge clk);
        ev_valid = 1'b0;
        m_q.push_back(sm2i(w));
    endtask

    task automatic do_step(output logic [16:0] got, output int lat);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lat = 0;
        while (!i_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = i_out;
        @(negedge clk);
        check("i_valid_pulse", 32'(i_valid), 32'd0);
    endtask

    initial begin
        logic [16:0] got;
        logic [16:0] exp;
        logic [16:0] first_out;
        int lat;
        int first_lat;
        int n;
        int accepts;
        int pulses;
        bit ready_bad;
        bit seen_valid;

        vecs[0] = '{1'b1, 3, '{17'h00100, 17'h00280, 17'h10080}, 17'h00300, 4, 1'b0};
        vecs[1] = '{1'b0, 0, '{17'h0, 17'h0, 17'h0}, 17'h00240, 1, 1'b0};
        vecs[2] = '{1'b1, 1, '{17'h10300, 17'h0, 17'h0}, 17'h10300, 2, 1'b0};
        vecs[3] = '{1'b0, 0, '{17'h0, 17'h0, 17'h0}, 17'h10240, 1, 1'b0};
        vecs[4] = '{1'b1, 1, '{17'h10000, 17'h0, 17'h0}, 17'h00000, 2, 1'b0};
        vecs[5] = '{1'b1, 2, '{17'h0C800, 17'h0C800, 17'h0}, 17'h0FFFF, 3, 1'b1};
        vecs[6] = '{1'b0, 0, '{17'h0, 17'h0, 17'h0}, 17'h0C000, 1, 1'b1};
        vecs[7] = '{1'b0, 2, '{17'h1FFFF, 17'h1FFFF, 17'h0}, 17'h1FFFF, 3, 1'b1};

        // Reset asserted mid-cycle from time zero; outputs must already be idle.
        #3;
        check("rst_i_out", 32'(i_out), 32'd0);
        check("rst_i_valid", 32'(i_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        @(negedge clk);
        check("rst_ev_ready", 32'(ev_ready), 32'd1);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst) do_reset();
            for (int k = 0; k < vecs[v].n; k++) push(vecs[v].w[k]);
            do_step(got, lat);
            check($sformatf("vec%0d_out", v), 32'(got), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_sat", v), 32'(sat), 32'(vecs[v].exp_sat));
        end

        // Backpressure: ten offered, only DEPTH accepted; step re-asserted mid-DRAIN.
        do_reset();
        accepts = 0;
        ev_valid = 1'b1;
        ev_weight = 17'h00100;
        for (int i = 0; i < 10; i++) begin
            if (ev_ready) accepts++;
            @(negedge clk);
        end
        ev_valid = 1'b0;
        check("full_accepts", 32'(accepts), 32'(DEPTH));
        check("full_ready_low", 32'(ev_ready), 32'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        pulses = 0;
        ready_bad = 1'b0;
        seen_valid = 1'b0;
        first_out = '0;
        first_lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (busy && ev_ready) ready_bad = 1'b1;
            if (i_valid) begin
                pulses++;
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    first_out = i_out;
                    first_lat = c;
                end
            end
            step = (c >= 2 && c <= 4);
            @(negedge clk);
        end
        step = 1'b0;
        check("full_out", 32'(first_out), 32'h00800);
        check("full_lat", 32'(first_lat), 32'd9);
        check("full_ready_in_drain", 32'(ready_bad), 32'd0);
        check("step_in_drain_pulses", 32'(pulses), 32'd1);
        check("full_ready_after", 32'(ev_ready), 32'd1);

        // Reset while draining: no publish, state fully cleared.
        do_reset();
        push(17'h0C800);
        push(17'h0C800);
        do_step(got, lat);
        check("pre_rst_sat", 32'(sat), 32'd1);
        for (int k = 0; k < 3; k++) push(17'h00100);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("mid_drain_busy", 32'(busy), 32'd1);
        #2 asyn_reset = 1'b1;
        #1;
        check("mid_rst_i_out", 32'(i_out), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_i_valid", 32'(i_valid), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_ev_ready", 32'(ev_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (i_valid) pulses++;
            @(negedge clk);
        end
        check("mid_rst_no_publish", 32'(pulses), 32'd0);
        do_step(got, lat);
        check("mid_rst_step_out", 32'(got), 32'd0);
        check("mid_rst_step_lat", 32'(lat), 32'd1);

        // Randomized timesteps against the reference model.
        do_reset();
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, DEPTH);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0)
                    push({1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF))});
                else
                    push({1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h0FFF))});
            end
            exp = model_step();
            do_step(got, lat);
            check($sformatf("rand%0d_out", r), 32'(got), 32'(exp));
            check($sformatf("rand%0d_lat", r), 32'(lat), 32'(n + 1));
            check($sformatf("rand%0d_sat", r), 32'(sat), 32'(m_sat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
